// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// FSM states, button events and BCD limits.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_W   = 4 * DIGIT_W;

    localparam logic [BCD_W-1:0] BCD_MAX = 16'h9999;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSED,
        LAP_RUN,
        LAP_PAUSED
    } sw_state_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_CLEAR,
        EV_START,
        EV_LAP
    } sw_event_e;

endpackage

// File: rtl/sw_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter,
// one-cycle registered press event on debounced 1->0.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk_point1hz,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       vld1_q;
    logic       vld2_q;
    logic       deb_q;
    logic       deb_d;
    logic       arm_q;
    logic       arm_d;
    logic       press_q;
    logic       press_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        // Arm only after a genuine released sample, so a press
        // held through reset cannot fire on reset release.
        arm_d   = arm_q | (vld2_q & sync2_q & deb_q);
        press_d = arm_q & deb_q & ~deb_d;
    end

    always_ff @(posedge clk_point1hz or posedge reset_n) begin
        if (reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            deb_q   <= 1'b1;
            arm_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            deb_q   <= deb_d;
            arm_q   <= arm_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: debounced buttons drive a run/pause/lap
// FSM that enables and clears the BCD counter and muxes display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter bit STOP_AT_MAX     = 1'b1
) (
    input  logic             clk_point1hz,
    input  logic             reset_n,
    input  logic             start_n,
    input  logic             lap_n,
    input  logic             clear_n,
    input  logic [BCD_W-1:0] live_bcd,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             running,
    output logic             lap_active,
    output logic             ovf
);

    logic start_ev;
    logic lap_ev;
    logic clear_ev;
    logic at_max;

    sw_event_e        ev;
    sw_state_e        state_q;
    sw_state_e        state_d;
    logic [BCD_W-1:0] snap_q;
    logic [BCD_W-1:0] snap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             clr_q;
    logic             clr_d;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk_point1hz(clk_point1hz),
        .reset_n     (reset_n),
        .btn_n       (start_n),
        .press       (start_ev)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk_point1hz(clk_point1hz),
        .reset_n     (reset_n),
        .btn_n       (lap_n),
        .press       (lap_ev)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk_point1hz(clk_point1hz),
        .reset_n     (reset_n),
        .btn_n       (clear_n),
        .press       (clear_ev)
    );

    assign at_max = STOP_AT_MAX && (live_bcd == BCD_MAX);

    always_comb begin
        if (clear_ev) begin
            ev = EV_CLEAR;
        end else if (start_ev) begin
            ev = EV_START;
        end else if (lap_ev) begin
            ev = EV_LAP;
        end else begin
            ev = EV_NONE;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev == EV_START) begin
                    state_d = RUN;
                end else if (ev == EV_CLEAR) begin
                    clr_d = 1'b1;
                    ovf_d = 1'b0;
                end
            end
            RUN: begin
                // Saturation beats any button so the counter never wraps.
                if (at_max) begin
                    state_d = PAUSED;
                    ovf_d   = 1'b1;
                end else if (ev == EV_START) begin
                    state_d = PAUSED;
                end else if (ev == EV_LAP) begin
                    state_d = LAP_RUN;
                    snap_d  = live_bcd;
                end
            end
            PAUSED: begin
                if (ev == EV_CLEAR) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else if (ev == EV_START) begin
                    state_d = RUN;
                end
            end
            LAP_RUN: begin
                if (at_max) begin
                    state_d = LAP_PAUSED;
                    ovf_d   = 1'b1;
                end else if (ev == EV_START) begin
                    state_d = LAP_PAUSED;
                end else if (ev == EV_LAP) begin
                    state_d = RUN;
                end
            end
            LAP_PAUSED: begin
                if (ev == EV_CLEAR) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else if (ev == EV_START) begin
                    state_d = LAP_RUN;
                end else if (ev == EV_LAP) begin
                    state_d = PAUSED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_point1hz or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
        end
    end

    assign running    = (state_q == RUN) || (state_q == LAP_RUN);
    assign lap_active = (state_q == LAP_RUN) || (state_q == LAP_PAUSED);
    assign cnt_en     = running && !at_max && !clr_q;
    assign cnt_clr    = clr_q;
    assign ovf        = ovf_q;
    assign disp_bcd   = lap_active ? snap_q : live_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: behavioural model checked every cycle,
// plus directed button sequences with literal expectations.
module tb_stopwatch_ctrl;

    localparam int D = 2;
    localparam logic [2:0] B_START = 3'b001;
    localparam logic [2:0] B_LAP   = 3'b010;
    localparam logic [2:0] B_CLR   = 3'b100;

    localparam int M_IDLE      = 0;
    localparam int M_RUN       = 1;
    localparam int M_PAUSED    = 2;
    localparam int M_LAPRUN    = 3;
    localparam int M_LAPPAUSED = 4;

    logic        clk_point1hz = 1'b0;
    logic        reset_n = 1'b1;
    logic        start_n = 1'b1;
    logic        lap_n = 1'b1;
    logic        clear_n = 1'b1;
    logic [15:0] live = 16'h0000;
    logic        cnt_en;
    logic        cnt_clr;
    logic [15:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_point1hz = ~clk_point1hz;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .STOP_AT_MAX    (1'b1)
    ) dut (
        .clk_point1hz(clk_point1hz),
        .reset_n     (reset_n),
        .start_n     (start_n),
        .lap_n       (lap_n),
        .clear_n     (clear_n),
        .live_bcd    (live),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .disp_bcd    (disp_bcd),
        .running     (running),
        .lap_active  (lap_active),
        .ovf         (ovf)
    );

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int x;
        x = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100
          + int'(v[7:4]) * 10 + int'(v[3:0]);
        x = (x + 1) % 10000;
        return {4'(x / 1000), 4'((x / 100) % 10),
                4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    // Model state
    int          m_st;
    logic [15:0] m_snap;
    logic        m_ovf;
    logic        m_clr;
    int          n_edge;
    int          act;
    logic [15:0] hist [3];
    logic [1:0]  rawh [3];
    logic        lvl [3];
    logic        armd [3];
    logic        pend [3];
    int          lastchg [3];

    function automatic logic m_run();
        return (m_st == M_RUN) || (m_st == M_LAPRUN);
    endfunction

    function automatic logic m_lap();
        return (m_st == M_LAPRUN) || (m_st == M_LAPPAUSED);
    endfunction

    task automatic m_reset();
        m_st   = M_IDLE;
        m_snap = 16'h0000;
        m_ovf  = 1'b0;
        m_clr  = 1'b0;
        n_edge = 0;
        act    = 0;
        for (int b = 0; b < 3; b++) begin
            hist[b]    = '1;
            rawh[b]    = 2'b11;
            lvl[b]     = 1'b1;
            armd[b]    = 1'b0;
            pend[b]    = 1'b0;
            lastchg[b] = 0;
        end
    endtask

    task automatic m_step();
        logic [2:0] raw;
        logic       evs [3];
        logic       atmax;
        int         e;
        raw = {clear_n, lap_n, start_n};
        atmax = (live == 16'h9999);
        act = m_clr ? 2 : ((m_run() && !atmax) ? 1 : 0);
        n_edge++;
        for (int b = 0; b < 3; b++) begin
            logic s;
            logic lv0;
            logic diff;
            evs[b] = pend[b];
            pend[b] = 1'b0;
            s = (n_edge >= 3) ? rawh[b][1] : 1'b1;
            rawh[b] = {rawh[b][0], raw[b]};
            hist[b] = {hist[b][14:0], s};
            lv0 = lvl[b];
            diff = (n_edge - lastchg[b]) >= D;
            for (int k = 0; k < D; k++) begin
                if (hist[b][k] == lvl[b]) diff = 1'b0;
            end
            if (diff) begin
                lvl[b] = ~lvl[b];
                lastchg[b] = n_edge;
                if (!lvl[b] && armd[b]) pend[b] = 1'b1;
            end
            if (n_edge >= 3 && s && lv0) armd[b] = 1'b1;
        end
        e = evs[2] ? 3 : (evs[0] ? 1 : (evs[1] ? 2 : 0));
        m_clr = 1'b0;
        case (m_st)
            M_IDLE: begin
                if (e == 1) m_st = M_RUN;
                else if (e == 3) m_clr = 1'b1;
            end
            M_RUN: begin
                if (atmax) begin
                    m_st = M_PAUSED;
                    m_ovf = 1'b1;
                end else if (e == 1) begin
                    m_st = M_PAUSED;
                end else if (e == 2) begin
                    m_st = M_LAPRUN;
                    m_snap = live;
                end
            end
            M_PAUSED: begin
                if (e == 3) begin
                    m_st = M_IDLE;
                    m_clr = 1'b1;
                    m_ovf = 1'b0;
                end else if (e == 1) begin
                    m_st = M_RUN;
                end
            end
            M_LAPRUN: begin
                if (atmax) begin
                    m_st = M_LAPPAUSED;
                    m_ovf = 1'b1;
                end else if (e == 1) begin
                    m_st = M_LAPPAUSED;
                end else if (e == 2) begin
                    m_st = M_RUN;
                end
            end
            default: begin
                if (e == 3) begin
                    m_st = M_IDLE;
                    m_clr = 1'b1;
                    m_ovf = 1'b0;
                end else if (e == 1) begin
                    m_st = M_LAPRUN;
                end else if (e == 2) begin
                    m_st = M_PAUSED;
                end
            end
        endcase
    endtask

    always @(posedge clk_point1hz or posedge reset_n) begin
        if (reset_n) m_reset();
        else m_step();
    end

    // Counter stand-in plus per-cycle compare
    always @(negedge clk_point1hz) begin
        logic exp_en;
        if (act == 2) live = 16'h0000;
        else if (act == 1) live = bcd_inc(live);
        act = 0;
        #1;
        exp_en = m_run() && (live != 16'h9999) && !m_clr;
        chk("cyc_running", 16'(running), 16'(m_run()));
        chk("cyc_lap_active", 16'(lap_active), 16'(m_lap()));
        chk("cyc_cnt_en", 16'(cnt_en), 16'(exp_en));
        chk("cyc_cnt_clr", 16'(cnt_clr), 16'(m_clr));
        chk("cyc_ovf", 16'(ovf), 16'(m_ovf));
        chk("cyc_disp", disp_bcd, m_lap() ? m_snap : live);
    end

    task automatic drive(input logic [2:0] m, input logic v);
        if (m[0]) start_n = v;
        if (m[1]) lap_n = v;
        if (m[2]) clear_n = v;
    endtask

    task automatic push(input logic [2:0] m, input int edges);
        @(negedge clk_point1hz);
        #3;
        drive(m, 1'b0);
        repeat (edges) @(posedge clk_point1hz);
        #1;
    endtask

    task automatic rel();
        @(negedge clk_point1hz);
        #3;
        drive(3'b111, 1'b1);
        repeat (8) @(posedge clk_point1hz);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic reached;
        repeat (3) @(posedge clk_point1hz);
        #1;
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_cnt_en", 16'(cnt_en), 16'd0);
        chk("rst_cnt_clr", 16'(cnt_clr), 16'd0);
        chk("rst_ovf", 16'(ovf), 16'd0);
        chk("rst_disp", disp_bcd, 16'h0000);
        @(negedge clk_point1hz);
        #3;
        reset_n = 1'b0;
        repeat (6) @(posedge clk_point1hz);

        // One-cycle glitch is filtered
        @(negedge clk_point1hz);
        #3;
        start_n = 1'b0;
        @(negedge clk_point1hz);
        #3;
        start_n = 1'b1;
        repeat (10) @(posedge clk_point1hz);
        #1;
        chk("glitch_running", 16'(running), 16'd0);
        chk("glitch_cnt_en", 16'(cnt_en), 16'd0);

        // Start latency: D+3 = 5 edges
        push(B_START, 4);
        chk("lat4_running", 16'(running), 16'd0);
        @(posedge clk_point1hz);
        #1;
        chk("lat5_running", 16'(running), 16'd1);
        chk("lat5_cnt_en", 16'(cnt_en), 16'd1);
        rel();
        push(B_START, 5);
        chk("pause_running", 16'(running), 16'd0);
        chk("pause_cnt_en", 16'(cnt_en), 16'd0);
        rel();

        // Lap snapshot
        push(B_START, 5);
        rel();
        push(B_LAP, 4);
        @(negedge clk_point1hz);
        #3;
        live = 16'h0042;
        @(posedge clk_point1hz);
        #1;
        chk("lap_active", 16'(lap_active), 16'd1);
        chk("lap_disp", disp_bcd, 16'h0042);
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(posedge clk_point1hz);
            #1;
            if (live == 16'h0050) reached = 1'b1;
        end
        chk("lap_reach_0050", 16'(reached), 16'd1);
        chk("lap_hold_disp", disp_bcd, 16'h0042);
        rel();
        push(B_LAP, 5);
        chk("unlap_active", 16'(lap_active), 16'd0);
        chk("unlap_disp", disp_bcd, live);
        rel();

        // Clear ignored in RUN
        push(B_CLR, 5);
        chk("runclr_cnt_clr", 16'(cnt_clr), 16'd0);
        chk("runclr_running", 16'(running), 16'd1);
        @(posedge clk_point1hz);
        #1;
        chk("runclr_cnt_clr2", 16'(cnt_clr), 16'd0);
        rel();

        // Clear from PAUSED
        push(B_START, 5);
        rel();
        push(B_CLR, 5);
        chk("pclr_cnt_clr", 16'(cnt_clr), 16'd1);
        chk("pclr_running", 16'(running), 16'd0);
        @(posedge clk_point1hz);
        #1;
        chk("pclr_cnt_clr_off", 16'(cnt_clr), 16'd0);
        rel();

        // Saturation at 9999
        push(B_START, 5);
        rel();
        @(negedge clk_point1hz);
        #3;
        live = 16'h9999;
        #1;
        chk("max_cnt_en", 16'(cnt_en), 16'd0);
        chk("max_ovf_pre", 16'(ovf), 16'd0);
        @(posedge clk_point1hz);
        #1;
        chk("max_ovf", 16'(ovf), 16'd1);
        chk("max_running", 16'(running), 16'd0);
        push(B_CLR, 5);
        chk("ovfclr_ovf", 16'(ovf), 16'd0);
        chk("ovfclr_cnt_clr", 16'(cnt_clr), 16'd1);
        rel();

        // Clear beats start in PAUSED
        push(B_START, 5);
        rel();
        push(B_START, 5);
        rel();
        push(B_START | B_CLR, 5);
        chk("prio_running", 16'(running), 16'd0);
        chk("prio_cnt_clr", 16'(cnt_clr), 16'd1);
        rel();

        // Asynchronous reset mid-RUN
        push(B_START, 5);
        rel();
        @(negedge clk_point1hz);
        #3;
        reset_n = 1'b1;
        #1;
        chk("arst_cnt_en", 16'(cnt_en), 16'd0);
        chk("arst_running", 16'(running), 16'd0);
        repeat (3) @(posedge clk_point1hz);
        @(negedge clk_point1hz);
        #3;
        reset_n = 1'b0;
        repeat (6) @(posedge clk_point1hz);

        // Press held through reset yields no event
        @(negedge clk_point1hz);
        #3;
        start_n = 1'b0;
        repeat (3) @(posedge clk_point1hz);
        @(negedge clk_point1hz);
        #3;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_point1hz);
        @(negedge clk_point1hz);
        #3;
        reset_n = 1'b0;
        repeat (15) @(posedge clk_point1hz);
        #1;
        chk("held_running", 16'(running), 16'd0);
        rel();
        push(B_START, 5);
        chk("repress_running", 16'(running), 16'd1);
        rel();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control front-end for the 4-digit BCD stopwatch counter.
- Debounces three active-low buttons (start/stop, lap, clear) and sequences the counter through a run/pause/lap FSM.
- Drives the counter's count enable and synchronous clear.
- Muxes live or lap-frozen digits to the display path.
- Sits between the board buttons and the counter/display; shares the counter's clock clk_point1hz.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive stable samples required before a button level is accepted (1..15).
- STOP_AT_MAX, 1: 1 = halt counting at 9999 and set ovf; 0 = counter allowed to wrap 9999 -> 0000.

Ports:
- clk_point1hz  in  1  counter/controller clock.
- reset_n  in  1  asynchronous, active-high reset.
- start_n  in  1  raw start/stop button, active-low, asynchronous to clock.
- lap_n  in  1  raw lap button, active-low.
- clear_n  in  1  raw clear button, active-low.
- live_bcd  in  16  current counter digits {d3,d2,d1,d0}, 4 bits each.
- cnt_en  out  1  count enable to counter; counter increments on edges where cnt_en=1.
- cnt_clr  out  1  one-cycle synchronous clear pulse to counter.
- disp_bcd  out  16  digits to display: live_bcd, or lap snapshot while lap active.
- running  out  1  state is RUN or LAP_RUN.
- lap_active  out  1  state is LAP_RUN or LAP_PAUSED.
- ovf  out  1  sticky: count reached 9999 with STOP_AT_MAX=1.

Behaviour:
- Reset (async, reset_n=1):
  - state=IDLE; cnt_clr=0; ovf=0; snapshot=0.
  - Sync flops and debounced levels = 1 (released); debounce counters = 0.
  - Consequently cnt_en=0 and disp_bcd=live_bcd.
- Debounce, per button:
  - 2-FF synchronizer feeds a stability counter.
  - Debounced level takes the synced value after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level.
  - Any sample equal to the debounced level zeroes the counter.
  - Registered press event = debounced 1->0, high for exactly one cycle. Release generates no event.
- Latency: the state register updates on the edge after the press event. Total = DEBOUNCE_CYCLES+3 edges from the first edge that samples the raw input low.
- Event priority, same cycle: clear > start > lap. Lower-priority events in that cycle are dropped.
- FSM (state encoding in package):
  - IDLE: start -> RUN. Clear -> IDLE with cnt_clr pulse. Lap ignored.
  - RUN: start -> PAUSED. Lap -> LAP_RUN, snapshot<=live_bcd on the same edge. Clear ignored.
  - LAP_RUN: lap -> RUN (display released). Start -> LAP_PAUSED. Clear ignored.
  - PAUSED: start -> RUN. Clear -> IDLE, cnt_clr=1 for the next cycle, ovf<=0. Lap ignored.
  - LAP_PAUSED: start -> LAP_RUN. Lap -> PAUSED. Clear -> IDLE, cnt_clr pulse, ovf<=0, snapshot unchanged.
- cnt_en:
  - Combinational: 1 when state in {RUN, LAP_RUN} and NOT (STOP_AT_MAX and live_bcd==16'h9999).
  - Never high while cnt_clr is high.
- Max count (STOP_AT_MAX=1):
  - When live_bcd==9999 in RUN/LAP_RUN, ovf<=1 on that edge and state moves to PAUSED/LAP_PAUSED respectively.
  - The counter therefore never wraps.
- disp_bcd: snapshot when lap_active, else live_bcd. Pure mux, no added latency.
- Reset mid-operation: immediate return to IDLE outputs. A press held through reset produces no event after release of reset until it is released and pressed again.
- A button held continuously yields exactly one event.

Decomposition:
- Package stopwatch_pkg: FSM state enum (IDLE, RUN, PAUSED, LAP_RUN, LAP_PAUSED), BCD_MAX=16'h9999, digit width 4.
- Sub-module sw_debounce (synchronizer + stability counter + falling-edge event), instantiated three times, parameter DEBOUNCE_CYCLES.

Test Plan:
- DEBOUNCE_CYCLES=2, reset, pulse start_n low 5 cycles -> running=1 and cnt_en=1 exactly 5 edges after first low sample; a second identical press -> PAUSED, cnt_en=0.
- Start_n glitch low for 1 cycle (shorter than debounce) -> no event, state stays IDLE, cnt_en=0.
- RUN at live_bcd=0042, press lap -> disp_bcd=0042 held while live advances to 0050; press lap again -> disp_bcd follows live.
- PAUSED, press clear -> cnt_clr high exactly one cycle, state IDLE; clear pressed in RUN -> no cnt_clr.
- STOP_AT_MAX=1, RUN with live_bcd driven to 9999 -> cnt_en=0 that cycle, ovf=1, state PAUSED; clear -> ovf=0.
- Clear and start debounced in same cycle while PAUSED -> IDLE with cnt_clr pulse, not RUN; assert reset_n mid-RUN -> cnt_en=0 asynchronously.
